// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks: default
// geometry and width-generic binary/Gray conversion helpers.
package fifo_pkg;

  localparam int ASIZE_DEF = 4;
  localparam int DEPTH     = 2 ** ASIZE_DEF;
  localparam int PTR_W     = ASIZE_DEF + 1;

  // Binary to Gray. Operates on a 32-bit container so any pointer width up to
  // 32 can use it; callers zero-extend the input and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 5'd1);
  endfunction

  // Gray to binary. Each binary bit is the XOR of all Gray bits at or above it;
  // the doubling shifts build that prefix XOR for any width up to 32.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 5'd1);
    b = b ^ (b >> 5'd2);
    b = b ^ (b >> 5'd4);
    b = b ^ (b >> 5'd8);
    b = b ^ (b >> 5'd16);
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary counter with a registered Gray copy. Shared by the write-side full
// block and the read-side empty block of the asynchronous FIFO.
module fifo_gray_ptr
  import fifo_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-2:0] addr_o,
  output logic [W-1:0] gray_o,
  output logic [W-1:0] gray_next_o
);

  logic [W-1:0] bin_q;
  logic [W-1:0] bin_d;
  logic [W-1:0] gray_q;
  logic [W-1:0] gray_d;

  // Next binary count wraps naturally at 2**W; Gray is derived from it so the
  // published pointer changes one bit per increment.
  always_comb begin
    bin_d  = bin_q + W'(inc_i);
    gray_d = W'(bin2gray(32'(bin_d)));
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= {W{1'b0}};
      gray_q <= {W{1'b0}};
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign addr_o      = bin_q[W-2:0];
  assign gray_o      = gray_q;
  assign gray_next_o = gray_d;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag logic for the asynchronous FIFO.
// Drives RAM write address/strobe, publishes the Gray write pointer and
// raises full/overflow from the read pointer already synchronised into clk.
// Optional almost-full flag built only when FIFO_WPTR_AFULL_EN is defined;
// otherwise wafull is tied low.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ASIZE     = ASIZE_DEF,
  parameter int AF_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             wovf,
  output logic             wafull
);

  localparam int PW  = ASIZE + 1;
  localparam int DEP = 2 ** ASIZE;

  if (ASIZE < 2 || AF_MARGIN < 1 || AF_MARGIN >= DEP) begin : g_bad_param
    $error("fifo_wptr_full: illegal ASIZE/AF_MARGIN combination");
  end

  logic          acc_s;
  logic [PW-1:0] gray_s;
  logic [PW-1:0] gray_d;
  logic          full_q;
  logic          full_d;
  logic          ovf_q;
  logic          ovf_d;

  // A write is taken only while not full; full is the registered flag so the
  // strobe has no combinational path from the read-side pointer.
  assign acc_s = winc & ~full_q;

  fifo_gray_ptr #(.W(PW)) u_ptr (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (acc_s),
    .addr_o      (waddr),
    .gray_o      (gray_s),
    .gray_next_o (gray_d)
  );

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that is the top two bits inverted, rest equal.
  // Overflow is sticky once a write is attempted against a full FIFO.
  always_comb begin
    full_d = (gray_d == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
    ovf_d  = ovf_q | (winc & full_q);
  end

  // Flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef FIFO_WPTR_AFULL_EN
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_s;
  logic          afull_q;
  logic          afull_d;

  // Fill level from the next write count and the synchronised read count.
  // The next binary count is recovered from the Gray next-state so the
  // shared pointer block keeps a single interface for both FIFO sides.
  always_comb begin
    wbin_next_s = PW'(gray2bin(32'(gray_d)));
    rbin_s      = PW'(gray2bin(32'(wq2_rptr)));
    level_s     = wbin_next_s - rbin_s;
    afull_d     = (level_s >= PW'(DEP - AF_MARGIN));
  end

  // Almost-full register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign wafull = afull_q;
`else
  assign wafull = 1'b0;
`endif

  assign wen   = acc_s;
  assign wptr  = gray_s;
  assign wfull = full_q;
  assign wovf  = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ASIZE=4, AF_MARGIN=2). The model
// tracks plain write/read entry counts and derives every flag from the fill
// level; the read pointer fed to the DUT is the Gray form of the model count.
module tb_fifo_wptr_full;
  import fifo_pkg::*;

  localparam int AFM = 2;
`ifdef FIFO_WPTR_AFULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       wovf;
  logic       wafull;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: total entries written / read, modulo 32, and flags.
  int m_wr = 0;
  int m_rd = 0;
  bit m_full = 1'b0;
  bit m_ovf = 1'b0;
  bit m_afull = 1'b0;

  fifo_wptr_full #(.ASIZE(4), .AF_MARGIN(AFM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .wen      (wen),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wovf     (wovf),
    .wafull   (wafull)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  // Apply inputs away from the clock edge and let combinational outputs settle.
  task automatic drive(input logic w, input logic rn);
    winc     = w;
    rst_n    = rn;
    wq2_rptr = to_gray(m_rd);
    #1;
  endtask

  // Advance one clock and step the model by the rules of the block.
  task automatic clk_edge();
    int lvl;
    @(posedge clk);
    if (!rst_n) begin
      m_wr = 0; m_full = 1'b0; m_ovf = 1'b0; m_afull = 1'b0;
    end else begin
      if (winc && m_full) m_ovf = 1'b1;
      if (winc && !m_full) m_wr = (m_wr + 1) % 32;
      lvl     = (m_wr - m_rd + 32) % 32;
      m_full  = (lvl == DEPTH);
      m_afull = AF_ON && (lvl >= DEPTH - AFM);
    end
    #1;
  endtask

  task automatic test_reset();
    m_rd = 0;
    drive(1'b1, 1'b0); clk_edge();
    drive(1'b1, 1'b0); clk_edge();
    n_checks++; if (wptr !== 5'b00000) begin n_errors++; $display("FAIL reset_wptr: got %b want 00000", wptr); end
    n_checks++; if (waddr !== 4'd0) begin n_errors++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
    n_checks++; if (wfull !== 1'b0) begin n_errors++; $display("FAIL reset_wfull: got %b want 0", wfull); end
    n_checks++; if (wovf !== 1'b0) begin n_errors++; $display("FAIL reset_wovf: got %b want 0", wovf); end
    n_checks++; if (wafull !== 1'b0) begin n_errors++; $display("FAIL reset_wafull: got %b want 0", wafull); end
    drive(1'b0, 1'b1);
    n_checks++; if (wen !== 1'b0) begin n_errors++; $display("FAIL reset_wen: got %b want 0", wen); end
  endtask

  task automatic test_fill();
    m_rd = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1);
      n_checks++; if (wen !== 1'b1 || waddr !== 4'(i)) begin n_errors++; $display("FAIL fill_addr: got wen=%b waddr=%0d want wen=1 waddr=%0d", wen, waddr, i); end
      clk_edge();
      n_checks++; if (wfull !== m_full) begin n_errors++; $display("FAIL fill_wfull%0d: got %b want %b", i, wfull, m_full); end
    end
    n_checks++; if (wptr !== 5'b11000) begin n_errors++; $display("FAIL fill_wptr: got %b want 11000", wptr); end
    n_checks++; if (wfull !== 1'b1) begin n_errors++; $display("FAIL fill_full: got %b want 1", wfull); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      n_checks++; if (wen !== 1'b0) begin n_errors++; $display("FAIL ovf_wen: got %b want 0", wen); end
      clk_edge();
      n_checks++; if (wptr !== 5'b11000 || wovf !== 1'b1 || wfull !== 1'b1) begin n_errors++; $display("FAIL ovf_hold: got wptr=%b wovf=%b wfull=%b want 11000 1 1", wptr, wovf, wfull); end
    end
    drive(1'b0, 1'b1); clk_edge();
    n_checks++; if (wovf !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b want 1", wovf); end
  endtask

  task automatic test_drain();
    m_rd = 1;
    drive(1'b1, 1'b1);
    n_checks++; if (wen !== 1'b0) begin n_errors++; $display("FAIL drain_wen: got %b want 0", wen); end
    clk_edge();
    n_checks++; if (wfull !== 1'b0 || wptr !== 5'b11000) begin n_errors++; $display("FAIL drain_clear: got wfull=%b wptr=%b want 0 11000", wfull, wptr); end
    drive(1'b1, 1'b1);
    n_checks++; if (wen !== 1'b1 || waddr !== 4'd0) begin n_errors++; $display("FAIL drain_addr: got wen=%b waddr=%0d want 1 0", wen, waddr); end
    clk_edge();
    n_checks++; if (wfull !== 1'b1) begin n_errors++; $display("FAIL drain_refull: got %b want 1", wfull); end
  endtask

  task automatic test_midop_reset();
    m_rd = m_wr;
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b1); clk_edge(); end
    drive(1'b1, 1'b0); clk_edge();
    m_rd = 0;
    n_checks++; if (wptr !== 5'b00000 || waddr !== 4'd0 || wovf !== 1'b0) begin n_errors++; $display("FAIL midrst: got wptr=%b waddr=%0d wovf=%b want 00000 0 0", wptr, waddr, wovf); end
  endtask

  task automatic test_wrap();
    m_rd = 0;
    drive(1'b0, 1'b0); clk_edge();
    for (int i = 0; i < 16; i++) begin drive(1'b1, 1'b1); clk_edge(); end
    m_rd = 16;
    drive(1'b0, 1'b1); clk_edge();
    n_checks++; if (wfull !== 1'b0) begin n_errors++; $display("FAIL wrap_unfull: got %b want 0", wfull); end
    for (int i = 0; i < 16; i++) begin drive(1'b1, 1'b1); clk_edge(); end
    n_checks++; if (wptr !== 5'b00000 || wfull !== 1'b1) begin n_errors++; $display("FAIL wrap_full: got wptr=%b wfull=%b want 00000 1", wptr, wfull); end
  endtask

  task automatic test_afull();
    m_rd = 0;
    drive(1'b0, 1'b0); clk_edge();
    for (int i = 0; i < 13; i++) begin drive(1'b1, 1'b1); clk_edge(); end
    n_checks++; if (wafull !== 1'b0) begin n_errors++; $display("FAIL afull13: got %b want 0", wafull); end
    drive(1'b1, 1'b1); clk_edge();
    n_checks++; if (wafull !== AF_ON) begin n_errors++; $display("FAIL afull14: got %b want %b", wafull, AF_ON); end
  endtask

  task automatic test_random();
    bit w;
    bit rn;
    for (int c = 0; c < 600; c++) begin
      w  = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 149) != 0);
      if (!rn) m_rd = 0;
      else if (((m_wr - m_rd + 32) % 32) > 0 && $urandom_range(0, 2) == 0) m_rd = (m_rd + 1) % 32;
      drive(w, rn);
      n_checks++; if (wen !== (w && !m_full) || waddr !== 4'(m_wr % 16)) begin n_errors++; $display("FAIL rnd_comb c=%0d: got wen=%b waddr=%0d want %b %0d", c, wen, waddr, (w && !m_full), m_wr % 16); end
      clk_edge();
      n_checks++; if (wptr !== to_gray(m_wr) || wfull !== m_full || wovf !== m_ovf || wafull !== m_afull) begin
        n_errors++;
        $display("FAIL rnd_regs c=%0d: got wptr=%b wfull=%b wovf=%b wafull=%b want %b %b %b %b", c, wptr, wfull, wovf, wafull, to_gray(m_wr), m_full, m_ovf, m_afull);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_midop_reset();
    test_wrap();
    test_afull();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
